array_mult_seq: RTL
===================

Name: array_mult_seq

Overview:
Parametrised sequential successor to the 4x4 combinational array multiplier. It computes a WIDTH x WIDTH product over WIDTH clock cycles using radix-2 shift-add. It adds an optional two's-complement signed mode and valid/ready handshakes on both input and output, so it can sit between a register front-end and a result consumer that may stall.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..16); product width is 2*WIDTH.
SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair m, q, signed_mode is presented.
in_ready  output  1  block can accept operands this cycle.
m  input  WIDTH  multiplicand.
q  input  WIDTH  multiplier.
signed_mode  input  1  1 = operands are two's complement (only when SIGNED_EN=1).
out_valid  output  1  p holds a completed product.
out_ready  input  1  consumer takes p this cycle.
p  output  2*WIDTH  product.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high, sampled on the rising edge. On reset: state=IDLE, in_ready=1, out_valid=0, p=0, internal accumulator, counter and sign flag all 0. Reset mid-RUN or in DONE aborts the operation; the partial result is discarded.
- States: IDLE, RUN, DONE; encoding from the package.
- IDLE: in_ready=1, out_valid=0.
  - Accept on a rising edge with in_valid && in_ready.
  - On accept, capture mag_m=|m| and mag_q=|q| as unsigned WIDTH bits. If signed (signed_mode && SIGNED_EN), take the two's-complement magnitude when the MSB is 1; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
  - On accept, set neg = signed && (m[MSB]^q[MSB]), set acc=0 and cnt=0, then go to RUN.
- RUN: in_ready=0, out_valid=0. One iteration per cycle:
  - If mag_q[0], the upper WIDTH+1 bits of acc += mag_m (carry kept).
  - Then acc and mag_q shift right 1 as a combined register; cnt++.
  - After exactly WIDTH iterations (cnt reaches WIDTH-1 on that edge), register p = neg ? -(acc) : acc, truncated to 2*WIDTH, and go to DONE.
- Latency: out_valid rises exactly WIDTH rising edges after the accepting edge (4 for WIDTH=4).
- DONE: out_valid=1, in_ready=0. p stays stable while out_valid=1 && !out_ready (no limit on stall length). On an edge with out_ready=1, go to IDLE and set out_valid=0.
- Throughput: one product per WIDTH+2 cycles at best. There is no overlap; a new accept is earliest on the edge after the output handshake.
- p after the handshake keeps its last value until the next DONE. The consumer must only use p when out_valid=1.
- Zero operand: the full WIDTH iterations still run; latency is fixed and data-independent.
- Signed with a zero result: neg may be 1 but -(0)=0, so p=0; no negative zero.
- Inputs are ignored whenever in_ready=0. in_valid high during RUN or DONE has no effect.
- X-free: every register has a defined reset value.

Decomposition:
- Shared package array_mult_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - function mult_width(WIDTH) returning 2*WIDTH;
  - counter width constant $clog2(WIDTH).
- One sub-module, mult_abs: combinational WIDTH-bit conditional two's-complement negate (inputs value and neg; output value or -value). Instantiated twice for operand magnitudes; the same logic is reused inline at 2*WIDTH for the final negate.

Test Plan:
1. WIDTH=4, unsigned. Sweep the legacy vectors: m=0,q=0 -> p=0x00; m=1,q=1 -> 0x01; m=2,q=2 -> 0x04; m=8,q=8 -> 0x40; m=3,q=3 -> 0x09. Each with out_valid exactly 4 edges after accept and out_ready=1.
2. Unsigned extreme: m=15, q=15, out_ready held 0 for 7 cycles. p=0xE1 stays stable with out_valid=1 throughout; on out_ready=1, out_valid drops next edge and in_ready=1.
3. Signed mode (signed_mode=1): m=-8 (1000), q=-8 -> p=0x40; m=-8, q=7 -> p=0xC8 (-56); m=-1, q=1 -> p=0xFF; m=0, q=-5 -> p=0x00.
4. Handshake: hold in_valid=1 and change m/q during RUN. The operands are not re-captured, and in_ready=0 for the 4 RUN cycles plus DONE. Back-to-back: the second accept occurs on the edge after the out handshake.
5. Reset mid-RUN: accept m=7,q=5, assert rst on the 2nd RUN edge. Next cycle: out_valid=0, p=0, in_ready=1. A fresh m=7,q=5 then yields p=0x23.
6. SIGNED_EN=0, WIDTH=8: signed_mode=1, m=0xFF, q=0xFF -> p=0xFE01 (unsigned) after exactly 8 edges. Exhaustive random unsigned/signed compare against a behavioural a*b model.

Source files
------------

// File: rtl/array_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   ST_IDLE/ST_RUN/ST_DONE : FSM state encoding
//   state_t                : FSM state type built on that encoding
//   mult_width(w)          : product width for a w-bit operand pair
//   cnt_width(w)           : iteration counter width for w iterations
package array_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int mult_width(input int width);
    return 2 * width;
  endfunction

  // Counter only has to hold 0..width-1; at least one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement negate.
//   value  : W-bit input
//   neg    : 1 = return -value, 0 = pass value through
//   result : W-bit output
// Used to turn a signed operand into its unsigned magnitude; the most
// negative input maps onto 2^(W-1), which is still representable unsigned.
module mult_abs #(
  parameter int W = 4
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? -value : value;

endmodule

// File: rtl/array_mult_seq.sv
// Sequential radix-2 shift-add multiplier, WIDTH iterations per product.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (m, q, signed_mode)
//   out_valid / out_ready : product handshake (p)
//   p                     : 2*WIDTH product, held until the next completion
// Signed operands are multiplied as magnitudes and the sign is re-applied
// to the final product, so the datapath itself is purely unsigned.
module array_mult_seq
  import array_mult_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              m,
  input  logic [WIDTH-1:0]              q,
  input  logic                          signed_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [mult_width(WIDTH)-1:0]  p
);

  localparam int PW = mult_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  state_t          state;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] mag_m;
  logic [WIDTH-1:0] mag_q;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic             is_signed;
  logic [WIDTH-1:0] abs_m;
  logic [WIDTH-1:0] abs_q;

  assign is_signed = SIGNED_EN && signed_mode;

  mult_abs #(.W(WIDTH)) u_abs_m (
    .value  (m),
    .neg    (is_signed & m[WIDTH-1]),
    .result (abs_m)
  );

  mult_abs #(.W(WIDTH)) u_abs_q (
    .value  (q),
    .neg    (is_signed & q[WIDTH-1]),
    .result (abs_q)
  );

  // One iteration: add into the upper half with a carry bit, then shift the
  // whole accumulator right so the carry lands in the top bit.
  logic [WIDTH:0]  sum;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   prod;

  always_comb begin
    sum      = {1'b0, acc[PW-1:WIDTH]} + (mag_q[0] ? {1'b0, mag_m} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
    // -(0) is 0, so a signed zero result never becomes negative zero.
    prod     = neg ? -acc_next : acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
      mag_m     <= '0;
      mag_q     <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mag_m    <= abs_m;
            mag_q    <= abs_q;
            neg      <= is_signed && (m[WIDTH-1] ^ q[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mag_q <= mag_q >> 1;
          cnt   <= cnt + CW'(1);
          // Last iteration: latch the finished product straight from the
          // combinational result so it is ready exactly WIDTH edges after accept.
          if (cnt == CW'(WIDTH - 1)) begin
            p         <= prod;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
